// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core load/store path and a debug port.
// Define DMEM_ARB_DBG_PRIO_EN to give the debug port fixed priority on ties.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("dmem_arbiter: MEM_LAT must be within 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  localparam logic CORE = 1'b0;
  localparam logic DBG  = 1'b1;

  state_e        state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          win, win_we;

  // Winner of the current request set; only consumed in IDLE.
  always_comb begin
    win = CORE;
    if (c_req && d_req) begin
`ifdef DMEM_ARB_DBG_PRIO_EN
      win = DBG;
`else
      win = (last_q == DBG) ? CORE : DBG;
`endif
    end else if (d_req) begin
      win = DBG;
    end
    win_we = (win == DBG) ? d_we : c_we;
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    last_d    = last_q;
    owner_d   = owner_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    c_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    c_stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_req || d_req) begin
          m_en    = 1'b1;
          m_we    = win_we;
          m_addr  = (win == DBG) ? d_addr  : c_addr;
          m_wdata = (win == DBG) ? d_wdata : c_wdata;
          c_gnt   = (win == CORE);
          d_gnt   = (win == DBG);
          last_d  = win;
          if (!win_we) begin
            owner_d = win;
            lat_d   = 4'(MEM_LAT);
            state_d = S_WAIT;
          end
        end
        c_stall = c_req & ~c_gnt;
      end
      S_WAIT: begin
        lat_d   = lat_q - 4'd1;
        c_stall = (owner_q == CORE) | c_req;
        // m_rdata is valid in the last WAIT cycle; register it for the RESP cycle.
        if (lat_q == 4'd1) begin
          state_d = S_RESP;
          if (owner_q == DBG) d_rdata_d = m_rdata;
          else                c_rdata_d = m_rdata;
        end
      end
      S_RESP: begin
        c_rvalid = (owner_q == CORE);
        d_rvalid = (owner_q == DBG);
        c_stall  = (owner_q == CORE) ? 1'b0 : c_req;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) begin
      c_gnt    = 1'b0;
      d_gnt    = 1'b0;
      c_rvalid = 1'b0;
      d_rvalid = 1'b0;
      m_en     = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      c_stall  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      last_q    <= DBG;
      owner_q   <= CORE;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: u1 runs with MEM_LAT=1, u4 with MEM_LAT=4, shared stimulus.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;

  logic        c_gnt1, c_rvalid1, c_stall1, d_gnt1, d_rvalid1, m_en1, m_we1;
  logic [31:0] c_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic        c_gnt4, c_rvalid4, c_stall4, d_gnt4, d_rvalid4, m_en4, m_we4;
  logic [31:0] c_rdata4, d_rdata4, m_addr4, m_wdata4, m_rdata4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1), .c_stall(c_stall1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u4 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt4), .c_rvalid(c_rvalid4), .c_rdata(c_rdata4), .c_stall(c_stall4),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4),
    .m_en(m_en4), .m_we(m_we4), .m_addr(m_addr4), .m_wdata(m_wdata4), .m_rdata(m_rdata4)
  );

  // Memory models: unwritten words read as 0xA500_00xx (xx = address byte).
  logic [31:0] wmem1 [256];
  logic [31:0] wmem4 [256];
  logic [255:0] wv1, wv4;
  logic [31:0] pipe1;
  logic [31:0] pipe4 [4];

  function automatic logic [31:0] rd(input logic [255:0] wv, input logic [31:0] w, input logic [7:0] a);
    return wv[a] ? w : (32'hA500_0000 | {24'd0, a});
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wv1 <= '0;
      wv4 <= '0;
    end else begin
      if (m_en1 && m_we1) begin wmem1[m_addr1[7:0]] <= m_wdata1; wv1[m_addr1[7:0]] <= 1'b1; end
      if (m_en4 && m_we4) begin wmem4[m_addr4[7:0]] <= m_wdata4; wv4[m_addr4[7:0]] <= 1'b1; end
    end
  end

  always @(posedge clk) begin
    pipe1    <= (m_en1 && !m_we1) ? rd(wv1, wmem1[m_addr1[7:0]], m_addr1[7:0]) : 32'h0;
    pipe4[0] <= (m_en4 && !m_we4) ? rd(wv4, wmem4[m_addr4[7:0]], m_addr4[7:0]) : 32'h0;
    for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
  end

  assign m_rdata1 = pipe1;
  assign m_rdata4 = pipe4[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    #4;
  endtask

  logic exp_c [12];
  logic exp_d [12];
  logic seen_d;
  int   c_rv_at;

  initial begin
    // Reset state, with a core request already pending.
    c_req = 1'b1; c_addr = 32'h10;
    nxt; nxt; smp;
    chk("rst_stall", c_stall1, 1);
    chk("rst_gnt", c_gnt1, 0);
    chk("rst_men", m_en1, 0);
    chk("rst_rdata", c_rdata1, 0);
    chk("rst_rvalid", c_rvalid1, 0);

    // Core read 0x10, MEM_LAT=1.
    nxt; rst = 1'b1; smp;
    chk("rd_gnt", c_gnt1, 1);
    chk("rd_men", m_en1, 1);
    chk("rd_maddr", m_addr1, 32'h10);
    chk("rd_mwe", m_we1, 0);
    nxt; c_req = 1'b0; smp;
    chk("rd_stall_t1", c_stall1, 1);
    chk("rd_rv_t1", c_rvalid1, 0);
    nxt; smp;
    chk("rd_rv_t2", c_rvalid1, 1);
    chk("rd_data", c_rdata1, 32'hA500_0010);
    chk("rd_stall_t2", c_stall1, 0);

    // Core write then read back.
    nxt; c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'hDEAD_BEEF; smp;
    chk("wr_gnt", c_gnt1, 1);
    chk("wr_mwe", m_we1, 1);
    chk("wr_wdata", m_wdata1, 32'hDEAD_BEEF);
    chk("wr_stall", c_stall1, 0);
    nxt; c_we = 1'b0; smp;
    chk("rb_gnt", c_gnt1, 1);
    chk("rb_mwe", m_we1, 0);
    nxt; c_req = 1'b0;
    nxt; smp;
    chk("rb_rv", c_rvalid1, 1);
    chk("rb_data", c_rdata1, 32'hDEAD_BEEF);

    // Both ports read continuously from reset.
    nxt; rst = 1'b0; c_req = 1'b1; d_req = 1'b1; c_addr = 32'h30; d_addr = 32'h40;
    nxt; nxt; rst = 1'b1; smp;
    for (int i = 0; i < 12; i++) begin
      exp_c[i] = 1'b0;
      exp_d[i] = 1'b0;
    end
`ifdef DMEM_ARB_DBG_PRIO_EN
    exp_d[0] = 1'b1; exp_d[3] = 1'b1; exp_d[6] = 1'b1; exp_d[9] = 1'b1;
`else
    exp_c[0] = 1'b1; exp_d[3] = 1'b1; exp_c[6] = 1'b1; exp_d[9] = 1'b1;
`endif
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin nxt; smp; end
      chk($sformatf("rr_cgnt%0d", i), c_gnt1, exp_c[i]);
      chk($sformatf("rr_dgnt%0d", i), d_gnt1, exp_d[i]);
    end

    // Debug read with MEM_LAT=4; core request waits through WAIT/RESP.
    nxt; rst = 1'b0; c_req = 1'b0; d_req = 1'b0;
    nxt; nxt; rst = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50; smp;
    chk("l4_dgnt", d_gnt4, 1);
    nxt; d_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h60; smp;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin nxt; smp; end
      chk($sformatf("l4_wait_cgnt%0d", i), c_gnt4, 0);
      chk($sformatf("l4_wait_drv%0d", i), d_rvalid4, 0);
      chk($sformatf("l4_wait_stall%0d", i), c_stall4, 1);
    end
    nxt; smp;
    chk("l4_drv", d_rvalid4, 1);
    chk("l4_ddata", d_rdata4, 32'hA500_0050);
    chk("l4_resp_cgnt", c_gnt4, 0);
    chk("l4_resp_stall", c_stall4, 1);
    nxt; smp;
    chk("l4_cgnt_after", c_gnt4, 1);
    nxt; c_req = 1'b0;
    nxt; nxt; nxt;
    nxt; smp;
    chk("l4_crv", c_rvalid4, 1);
    chk("l4_cdata", c_rdata4, 32'hA500_0060);
    chk("l4_dhold", d_rdata4, 32'hA500_0050);

    // Reset for one cycle in the middle of a debug read's WAIT.
    nxt; d_req = 1'b1; d_addr = 32'h70; smp;
    chk("mr_dgnt", d_gnt4, 1);
    nxt; d_req = 1'b0;
    nxt; rst = 1'b0; c_req = 1'b1; c_addr = 32'h10; smp;
    chk("mr_ddata_clr", d_rdata4, 0);
    chk("mr_cdata_clr", c_rdata4, 0);
    chk("mr_cgnt_in_rst", c_gnt4, 0);
    chk("mr_stall_in_rst", c_stall4, 1);
    nxt; rst = 1'b1; smp;
    chk("mr_cgnt_now", c_gnt4, 1);
    chk("mr_maddr", m_addr4, 32'h10);
    seen_d = 1'b0;
    c_rv_at = 0;
    for (int i = 1; i <= 8; i++) begin
      nxt;
      if (i == 1) c_req = 1'b0;
      smp;
      seen_d = seen_d | d_rvalid4;
      if (c_rvalid4) c_rv_at = i;
    end
    chk("mr_no_drv", seen_d, 0);
    chk("mr_crv_cycle", c_rv_at, 5);

    // Core pulses req for one cycle while debug owns the memory.
    nxt; d_req = 1'b1; d_addr = 32'h80; smp;
    chk("pl_dgnt", d_gnt4, 1);
    nxt; d_req = 1'b0; c_req = 1'b1; smp;
    chk("pl_cgnt", c_gnt4, 0);
    chk("pl_men", m_en4, 0);
    nxt; c_req = 1'b0; smp;
    chk("pl_men2", m_en4, 0);
    nxt; nxt;
    nxt; smp;
    chk("pl_drv", d_rvalid4, 1);
    chk("pl_ddata", d_rdata4, 32'hA500_0080);
    nxt; smp;
    chk("pl_idle_men", m_en4, 0);
    chk("pl_idle_cgnt", c_gnt4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
